// File: rtl/tqvp_reg_arbiter_if.sv
// Requester and peripheral bundle for the two-port register arbiter.
interface tqvp_reg_arbiter_if;
  // requester 0
  logic        r0_valid, r0_write;
  logic [1:0]  r0_width;
  logic [5:0]  r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_ready, r0_rvalid, r0_rerr;
  logic [31:0] r0_rdata;
  // requester 1
  logic        r1_valid, r1_write;
  logic [1:0]  r1_width;
  logic [5:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_ready, r1_rvalid, r1_rerr;
  logic [31:0] r1_rdata;
  // peripheral side
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        busy;

  // arbiter side
  modport slave (
    input  r0_valid, r0_write, r0_width, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rerr, r0_rdata,
    input  r1_valid, r1_write, r1_width, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rerr, r1_rdata,
    output address, data_in, data_write_n, data_read_n, busy,
    input  data_out, data_ready
  );

  // requesters plus peripheral model
  modport master (
    output r0_valid, r0_write, r0_width, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rerr, r0_rdata,
    output r1_valid, r1_write, r1_width, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rerr, r1_rdata,
    input  address, data_in, data_write_n, data_read_n, busy,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_reg_arbiter.sv
// Two-requester round-robin arbiter onto a single strobe-based register bus.
// Ready is combinational in IDLE; every other output is registered.
module tqvp_reg_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  tqvp_reg_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  width;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  req_t       req [2];
  req_t       g;
  logic [1:0] vld;
  logic       gnt_any, gnt_id;
  logic [1:0] rdy;

  logic        last_grant, owner;
  logic [1:0]  cmd_width;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        rerr_q;
  logic [1:0]  rvalid_o, rerr_o;
  logic [1:0][31:0] rdata_o;

  // gather requester inputs and pick the winner
  always_comb begin
    req[0]  = '{bus.r0_write, bus.r0_width, bus.r0_addr, bus.r0_wdata};
    req[1]  = '{bus.r1_write, bus.r1_width, bus.r1_addr, bus.r1_wdata};
    vld     = {bus.r1_valid, bus.r0_valid};
    gnt_any = |vld;
    gnt_id  = (&vld) ? ~last_grant : vld[1];
    g       = req[gnt_id];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and grant pulse
  always_comb begin
    state_nxt = state;
    rdy       = '0;
    case (state)
      IDLE: if (gnt_any) begin
        rdy[gnt_id] = 1'b1;
        if (g.width == 2'b11) state_nxt = g.write ? IDLE : RESP;
        else                  state_nxt = g.write ? WRITE : READ;
      end
      WRITE: state_nxt = IDLE;
      READ:  if (bus.data_ready || cnt == CNT_LAST) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // command capture, bus strobes, read capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      cmd_width        <= 2'b00;
      cnt              <= '0;
      rdata_q          <= '0;
      rerr_q           <= 1'b0;
      bus.address      <= '0;
      bus.data_in      <= '0;
      bus.data_write_n <= 2'b11;
      bus.data_read_n  <= 2'b11;
      rvalid_o         <= '0;
      rerr_o           <= '0;
      rdata_o          <= '0;
    end else begin
      rvalid_o <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          owner       <= gnt_id;
          last_grant  <= gnt_id;
          cmd_width   <= g.width;
          bus.address <= g.addr;
          bus.data_in <= g.wdata;
          cnt         <= '0;
          if (g.width == 2'b11) begin
            // illegal width: reads answer with an error, writes are dropped
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end else if (g.write) begin
            bus.data_write_n <= g.width;
          end else begin
            bus.data_read_n <= g.width;
          end
        end
        WRITE: bus.data_write_n <= 2'b11;
        READ: begin
          if (bus.data_ready) begin
            bus.data_read_n <= 2'b11;
            rerr_q          <= 1'b0;
            case (cmd_width)
              2'b00:   rdata_q <= {24'b0, bus.data_out[7:0]};
              2'b01:   rdata_q <= {16'b0, bus.data_out[15:0]};
              default: rdata_q <= bus.data_out;
            endcase
          end else if (cnt == CNT_LAST) begin
            bus.data_read_n <= 2'b11;
            rerr_q          <= 1'b1;
            rdata_q         <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          rvalid_o[owner] <= 1'b1;
          rdata_o[owner]  <= rdata_q;
          rerr_o[owner]   <= rerr_q;
        end
        default: ;
      endcase
    end
  end

  // ready is gated by reset so it stays low while rst_n is asserted
  assign bus.r0_ready  = rst_n & rdy[0];
  assign bus.r1_ready  = rst_n & rdy[1];
  assign bus.r0_rvalid = rvalid_o[0];
  assign bus.r1_rvalid = rvalid_o[1];
  assign bus.r0_rdata  = rdata_o[0];
  assign bus.r1_rdata  = rdata_o[1];
  assign bus.r0_rerr   = rerr_o[0];
  assign bus.r1_rerr   = rerr_o[1];
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/tqvp_reg_arbiter.md
TQVP_REG_ARBITER -- requirements
Module: tqvp_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of READ-state cycles spent waiting for data_ready (legal range 1..255).
REQ-002 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have requester ports, one set per requester N in {0,1}: rN_valid input 1 (request pending); rN_write input 1 (1=write, 0=read); rN_width input 2 (00 byte, 01 half, 10 word, 11 illegal); rN_addr input 6; rN_wdata input 32.
REQ-004 SHALL have requester response outputs: rN_ready output 1 (request accepted, one-cycle pulse); rN_rvalid output 1 (read response, one-cycle pulse); rN_rdata output 32; rN_rerr output 1 (read error, qualified by rN_rvalid).
REQ-005 SHALL have peripheral-side ports: address output 6; data_in output 32 (write data to peripheral); data_write_n output 2; data_read_n output 2; data_out input 32; data_ready input 1.
REQ-006 SHALL have busy output 1, high in any state other than IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, READ and RESP.
REQ-008 IDLE transitions:
- No valid request: stay in IDLE.
- One valid request: grant it.
- Both valid: grant the requester not granted most recently (round-robin).
REQ-009 On grant in IDLE:
- Pulse the granted rN_ready in the same cycle.
- Register addr, wdata, width and write into the command registers.
- Update last_grant.
REQ-010 Next state after a grant:
- rN_width=11: RESP with rerr=1 for a read; IDLE with no bus cycle for a write.
- Otherwise: WRITE if rN_write=1, else READ.
REQ-011 WRITE: data_write_n SHALL equal the registered width for exactly one cycle, with data_read_n=11; then return to IDLE.
REQ-012 READ entry: data_read_n SHALL equal the registered width, and SHALL be held until data_ready is sampled high or the timeout fires.
REQ-013 READ cycle count: an 8-bit counter SHALL clear on entry to READ and increment on each READ cycle.
REQ-014 READ completion: when data_ready=1 in READ, capture data_out masked by width and go to RESP with rerr=0.
- Byte: bits 31:8 forced to 0.
- Half: bits 31:16 forced to 0.
REQ-015 READ timeout: when the counter reaches TIMEOUT-1 with data_ready=0, go to RESP with rdata=0 and rerr=1.
REQ-016 Strobe release: data_read_n SHALL return to 11 in the cycle after data_ready or the timeout.
REQ-017 RESP: pulse rvalid, with rdata and rerr, only to the requester that issued the read, for one cycle; then return to IDLE.
REQ-018 rN_rdata and rN_rerr SHALL hold their last values between responses.
REQ-019 Registered outputs: address, data_in, data_write_n and data_read_n SHALL all be registered.
- address and data_in SHALL remain stable from the grant until the next grant.
REQ-020 Exclusivity: data_write_n and data_read_n SHALL never both be non-11 in the same cycle.
REQ-021 Back-to-back: a request presented in IDLE SHALL be accepted in that cycle, giving these minimum spacings:
- Writes: one every 2 cycles.
- Reads: 3 cycles plus peripheral latency.
REQ-022 data_ready SHALL be ignored outside READ.
REQ-023 rN_valid deasserted after acceptance SHALL have no effect on the transaction in flight.
REQ-024 The arbiter SHALL NOT start a new request while busy=1; requesters SHALL hold rN_valid until rN_ready.

Reset
REQ-025 While rst_n=0, regardless of clk: state=IDLE, data_write_n=11, data_read_n=11, address=0, data_in=0, all rN_ready/rN_rvalid/rN_rerr=0, all rN_rdata=0, busy=0, counter=0.
REQ-026 Reset state SHALL set last_grant=1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-transaction SHALL abort it with no strobe or response emitted afterwards; after release the arbiter SHALL resume from IDLE.

Verification
REQ-028 Single write: r0 writes word 0xA5A5_1234 to addr 0x05 -> r0_ready pulse; next cycle data_write_n=10, address=05, data_in=A5A51234, for one cycle only.
REQ-029 Byte read: r1 reads byte from addr 0x10 while the model returns data_out=0xDEADBEEF with data_ready 2 cycles after strobe -> data_read_n=00 held for 3 cycles; r1_rvalid with rdata=0x000000EF, rerr=0.
REQ-030 Contention: r0 and r1 valid together for three consecutive grants after reset -> grant order r0, r1, r0; r1 still pending meanwhile gets the next grant.
REQ-031 Timeout: read with data_ready never asserted, TIMEOUT=15 -> data_read_n held exactly 15 cycles; rvalid with rdata=0, rerr=1.
REQ-032 Illegal width: r0 read with width 11 -> no strobe on data_read_n/data_write_n; r0_rvalid with rerr=1 two cycles after acceptance.
REQ-033 Reset mid-read: rst_n low during READ -> data_read_n=11 immediately, no rvalid; next request after release completes normally.
